multiplicador_param: RTL and testbench
======================================

Name: multiplicador_param

Overview:
- Parametrised sequential shift-add multiplier. Generalises the fixed 4x4 unsigned multiplier to WIDTH-bit operands.
- Adds a per-operation signed/unsigned mode, with signed operands in two's complement.
- Uses a St/Idle/Done handshake. Used by the CPU datapath for MULT/MULTU, and standalone in the Multiplicador test harness.

Parameters:
WIDTH, 4, operand width in bits (>=2); product is 2*WIDTH bits

Ports:
Clk  input  1  clock, rising-edge active
Reset  input  1  asynchronous, active-low reset
St  input  1  start request, level-sensitive, sampled only in IDLE
Signed  input  1  1 = operands are two's complement, 0 = unsigned; sampled with St
Multiplicando  input  WIDTH  multiplicand; sampled with St
Multiplicador  input  WIDTH  multiplier; sampled with St
Produto  output  2*WIDTH  product register
Idle  output  1  high in IDLE only
Done  output  1  high in DONE only

Behaviour:
- Reset (Reset=0, asynchronous):
  - state IDLE; Produto=0, Idle=1, Done=0.
  - Internal accumulator, operand registers and counter are cleared.
  - Reset mid-operation aborts it; no partial result ever reaches Produto.
- Registered FSM with states IDLE, CALC, SIGN, DONE. Idle and Done decode directly from state, with no glitch paths from inputs.
- IDLE:
  - On an edge with St=1: latch Signed, Multiplicando and Multiplicador.
  - If Signed=1, convert each operand to its magnitude (WIDTH bits unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits).
  - Record neg = sign(A) XOR sign(B) when Signed=1, else neg=0.
  - Clear the 2*WIDTH accumulator, counter=0, go to CALC.
- CALC:
  - One step per edge: if multiplier LSB=1, add the shifted multiplicand to the upper half of the accumulator (carry kept), then shift accumulator/multiplier right 1.
  - Exactly WIDTH steps. On the edge performing step WIDTH, go to SIGN.
  - No early termination: latency is data-independent.
- SIGN:
  - On the next edge, Produto <= neg ? two's-complement negation of the accumulator : accumulator. Go to DONE.
  - Result is exact for all inputs; no overflow is possible in 2*WIDTH bits (max signed magnitude 2^(2*WIDTH-2)).
- DONE:
  - Done=1 and Produto held.
  - If St=0 on an edge, go to IDLE. If St=1, remain in DONE, so a held St yields exactly one operation; St must drop to re-arm.
- Latency: with St sampled high at edge E0, Done=1 and Produto valid after edge E0+WIDTH+1.
- Produto holds its previous value throughout CALC/SIGN. It updates only on the SIGN->DONE edge and keeps its value in IDLE until the next SIGN.
- Inputs changed after E0 have no effect on the running operation.
- St is ignored in CALC and SIGN.
- Signed=0 with MSB-set operands is treated as plain unsigned.
- Zero operands follow the normal WIDTH-step path; the result is 0, never negative zero.

Test Plan:
- WIDTH=4, Signed=0, 11x13, St pulsed high one cycle: Idle drops after E0; Done=1 after E0+5 edges; Produto=8'd143, held in DONE and after return to IDLE.
- WIDTH=4, Signed=1:
  - -3 (4'hD) x 5 -> Produto=8'hF1 (-15).
  - -8 x -8 -> 8'h40.
  - -8 x 7 -> 8'hC8 (-56).
  - 0 x -1 -> 8'h00.
- WIDTH=4, exhaustive, both modes: all 256 operand pairs with St pulsed per op and Done awaited. Every Produto must equal the reference product (i*j unsigned; sign-extended product signed) with no mismatch flagged.
- WIDTH=8, Signed=1: -128 x -128 -> 16'h4000; Signed=0, 255 x 255 -> 16'hFE01; Done after exactly 9 edges.
- St held high continuously: exactly one operation; Done stays 1 while St=1. After St=0 for one edge, Idle=1. St high again launches a new operation.
- Reset and operand stability:
  - Reset pulsed low during CALC step 2: immediately Produto=0, Idle=1, Done=0.
  - Operands toggled during CALC on a separate run: result reflects the E0 values only.

Source files
------------

// File: rtl/multiplicador_param.sv
// Sequential shift-add multiplier with a per-operation signed/unsigned mode.
// Uses the St/Idle/Done handshake. The product is 2*WIDTH bits and appears on
// Produto WIDTH+1 edges after St is sampled.
module multiplicador_param #(
  parameter int WIDTH = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 St,
  input  logic                 Signed,
  input  logic [WIDTH-1:0]     Multiplicando,
  input  logic [WIDTH-1:0]     Multiplicador,
  output logic [2*WIDTH-1:0]   Produto,
  output logic                 Idle,
  output logic                 Done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_prod;
  logic                 r_neg;
  logic [CW-1:0]        r_cnt;

  logic                 w_neg_a;
  logic                 w_neg_b;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_sum;

  // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
  assign w_neg_a  = Signed & Multiplicando[WIDTH-1];
  assign w_neg_b  = Signed & Multiplicador[WIDTH-1];
  assign w_mag_a  = w_neg_a ? (~Multiplicando + WIDTH'(1)) : Multiplicando;
  assign w_mag_b  = w_neg_b ? (~Multiplicador + WIDTH'(1)) : Multiplicador;

  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

  assign Produto  = r_prod;
  assign Idle     = (r_state == S_IDLE);
  assign Done     = (r_state == S_DONE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_prod   <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (St) begin
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_neg    <= w_neg_a ^ w_neg_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          // Carry out of the upper-half add becomes the new MSB after the shift.
          r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_SIGN;
          end
        end
        S_SIGN: begin
          r_prod  <= r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (!St) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_param.sv
// Scoreboarded bench for multiplicador_param at WIDTH=4 and WIDTH=8: stimulus
// pushes expected products, and monitors pop and compare on each rising Done.
module tb_multiplicador_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        st4 = 1'b0, sg4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  prod4;
  logic        idle4, done4;

  logic        st8 = 1'b0, sg8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] prod8;
  logic        idle8, done8;

  int checks = 0;
  int errors = 0;

  logic [7:0]  q4[$];
  logic [15:0] q8[$];
  logic        done4_q = 1'b0, done8_q = 1'b0;

  always #5 clk = ~clk;

  multiplicador_param #(.WIDTH(4)) dut4 (
    .Clk(clk), .Reset(rst_n), .St(st4), .Signed(sg4),
    .Multiplicando(a4), .Multiplicador(b4),
    .Produto(prod4), .Idle(idle4), .Done(done4)
  );

  multiplicador_param #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset(rst_n), .St(st8), .Signed(sg8),
    .Multiplicando(a8), .Multiplicador(b8),
    .Produto(prod8), .Idle(idle8), .Done(done8)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: one pop per rising edge of Done.
  always @(negedge clk) begin
    if (done4 && !done4_q) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb4 unexpected Done: got %h expected no result", prod4);
      end else begin
        logic [7:0] e;
        e = q4.pop_front();
        $display("TXN w4 prod=%h exp=%h", prod4, e);
        check("sb4 product", {8'h0, prod4}, {8'h0, e});
      end
    end
    if (done8 && !done8_q) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb8 unexpected Done: got %h expected no result", prod8);
      end else begin
        logic [15:0] e;
        e = q8.pop_front();
        $display("TXN w8 prod=%h exp=%h", prod8, e);
        check("sb8 product", prod8, e);
      end
    end
    done4_q = done4;
    done8_q = done8;
  end

  // One WIDTH=4 operation with St pulsed for one edge; optionally scrambles inputs mid-run.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sg,
                      input logic [7:0] exp, input bit scramble);
    int k;
    q4.push_back(exp);
    @(posedge clk); #1;
    a4 = a; b4 = b; sg4 = sg; st4 = 1'b1;
    @(posedge clk); #1;            // E0
    st4 = 1'b0;
    check("w4 idle drops after E0", {15'h0, idle4}, 16'h0000);
    if (scramble) begin
      a4 = 4'h8; b4 = 4'hF; sg4 = ~sg;
    end
    for (k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (scramble && k == 2) st4 = 1'b1;  // ignored while busy
      if (done4) break;
    end
    st4 = 1'b0;
    check("w4 latency", 16'(k), 16'd5);
    @(posedge clk); #1;
    check("w4 idle after done", {15'h0, idle4}, 16'h0001);
    check("w4 prod held in idle", {8'h0, prod4}, {8'h0, exp});
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sg,
                      input logic [15:0] exp);
    int k;
    q8.push_back(exp);
    @(posedge clk); #1;
    a8 = a; b8 = b; sg8 = sg; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    for (k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done8) break;
    end
    check("w8 latency", 16'(k), 16'd9);
    @(posedge clk); #1;
    check("w8 idle after done", {15'h0, idle8}, 16'h0001);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ai, bj;
    logic [7:0]  sa, sb, ev;
    int k;

    repeat (3) @(posedge clk);
    #1;
    check("reset prod4", {8'h0, prod4}, 16'h0000);
    check("reset idle4", {15'h0, idle4}, 16'h0001);
    check("reset done4", {15'h0, done4}, 16'h0000);
    check("reset prod8", prod8, 16'h0000);
    rst_n = 1'b1;

    // Directed vectors
    run4(4'd11, 4'd13, 1'b0, 8'd143, 1'b0);
    run4(4'hD,  4'd5,  1'b1, 8'hF1,  1'b0);
    run4(4'h8,  4'h8,  1'b1, 8'h40,  1'b0);
    run4(4'h8,  4'd7,  1'b1, 8'hC8,  1'b0);
    run4(4'h0,  4'hF,  1'b1, 8'h00,  1'b0);
    run4(4'hF,  4'hF,  1'b0, 8'hE1,  1'b0);
    run8(8'h80, 8'h80, 1'b1, 16'h4000);
    run8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    run8(8'hFF, 8'h02, 1'b1, 16'hFFFE);

    // Exhaustive WIDTH=4, both modes
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          ai = 4'(i);
          bj = 4'(j);
          if (s == 1) begin
            sa = {{4{ai[3]}}, ai};
            sb = {{4{bj[3]}}, bj};
            ev = 8'(sa * sb);
          end else begin
            ev = 8'(i * j);
          end
          run4(ai, bj, 1'(s), ev, 1'b0);
        end
      end
    end

    // St held high: one operation, Done stays up until St drops
    q4.push_back(8'd63);
    @(posedge clk); #1;
    a4 = 4'd7; b4 = 4'd9; sg4 = 1'b0; st4 = 1'b1;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done4) break;
    end
    check("held st latency", 16'(k), 16'd6);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      check("held st done stays", {15'h0, done4}, 16'h0001);
    end
    st4 = 1'b0;
    @(posedge clk); #1;
    check("held st idle after drop", {15'h0, idle4}, 16'h0001);
    run4(4'd3, 4'd5, 1'b0, 8'd15, 1'b0);

    // Reset during CALC step 2 aborts; Produto cleared immediately
    @(posedge clk); #1;
    a4 = 4'd11; b4 = 4'd13; sg4 = 1'b0; st4 = 1'b1;
    @(posedge clk); #1;
    st4 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort prod", {8'h0, prod4}, 16'h0000);
    check("abort idle", {15'h0, idle4}, 16'h0001);
    check("abort done", {15'h0, done4}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Operands and St toggled mid-operation have no effect
    run4(4'd11, 4'd13, 1'b0, 8'd143, 1'b1);
    run4(4'hD, 4'd5, 1'b1, 8'hF1, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    check("sb4 drained", 16'(q4.size()), 16'd0);
    check("sb8 drained", 16'(q8.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
